// File: rtl/exec_pkg.sv
// Shared opcode values and handshake-FSM state encoding for the execute-stage ALU.
package exec_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_LSL   = 4'b1001;
    localparam logic [3:0] ALU_LSR   = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, low WIDTH bits kept.
// done is raised for one cycle once all WIDTH iterations have been applied.
module seq_multiplier #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_prod;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_prod <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_prod <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            // Counter parks at WIDTH for the single done cycle, then the unit goes idle.
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                if (r_b[0]) begin
                    r_prod <= r_prod + r_a;
                end
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_busy && w_last;
    assign product = r_prod;

endmodule

// File: rtl/exec_alu_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus iterative MUL,
// with valid/ready handshakes on both sides and a registered result/zero output.
module exec_alu_unit
    import exec_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       alu_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_start;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic [WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0] w_alu_res;

    // Unknown opcodes (and MUL, which never takes this path) evaluate to zero.
    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] res;
        res = '0;
        case (op)
            ALU_AND:   res = a & b;
            ALU_ORR:   res = a | b;
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_PASSB: res = b;
            ALU_NOR:   res = ~(a | b);
            ALU_LSL:   res = a << b[5:0];
            ALU_LSR:   res = a >> b[5:0];
            default:   res = '0;
        endcase
        return res;
    endfunction

    assign in_ready    = (r_state == IDLE) && !w_mul_busy && (!r_out_valid || out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = (alu_op == ALU_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_alu_res   = alu_eval(alu_op, op_a, op_b);

    seq_multiplier #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_prod)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_mul_start) w_state_nxt = MUL;
            MUL:  if (w_mul_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output register: a held (unconsumed) result never changes because in_ready is low then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_result    <= w_alu_res;
            r_zero      <= (w_alu_res == '0);
            r_out_valid <= 1'b1;
        end else if (w_mul_start) begin
            r_out_valid <= 1'b0;
        end else if ((r_state == MUL) && w_mul_done) begin
            r_result    <= w_mul_prod;
            r_zero      <= (w_mul_prod == '0);
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_exec_alu_unit.sv
// Scoreboard bench for exec_alu_unit: expected results are queued at issue time
// and a monitor pops/compares on every output handshake.
module tb_exec_alu_unit;

    localparam int WIDTH = 64;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       alu_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    exec_alu_unit #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_output", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_result", result, e.res);
                check("sb_zero", {63'd0, zero}, {63'd0, e.z});
            end
        end
    end

    task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] er, input logic ez);
        exp_t e;
        e.res = er;
        e.z   = ez;
        q.push_back(e);
        in_valid = 1'b1;
        alu_op   = op;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic single(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er, input logic ez);
        drive(op, a, b, er, ez);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({name, "_lat1"}, {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic mul_run(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] er, input logic ez);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        drive(4'b1000, a, b, er, ez);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && n < 200) begin
            if (in_ready) bad++;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'd65);
        check({name, "_inready_low"}, 64'(bad), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        alu_op    = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 64'd0);
        check("rst_zero", {63'd0, zero}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD then SUB back to back
        drive(4'b0010, 64'd5, 64'd7, 64'd12, 1'b0);
        @(posedge clk); #1;
        check("add_out_valid", {63'd0, out_valid}, 64'd1);
        check("add_in_ready", {63'd0, in_ready}, 64'd1);
        drive(4'b0110, 64'd3, 64'd3, 64'd0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("sub_out_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk); #1;
        check("drain_out_valid", {63'd0, out_valid}, 64'd0);

        mul_run("mul_ffff", 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0001_FFFF_FFFE, 1'b0);
        mul_run("mul_trunc", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);
        mul_run("mul_mixed", 64'd12345, 64'd6789, 64'd83810205, 1'b0);

        single("lsl", 4'b1001, 64'd1, 64'd70, 64'h40, 1'b0);
        single("lsr", 4'b1010, 64'h8000_0000_0000_0000, 64'hFFC0_0000_0000_003F, 64'd1, 1'b0);
        single("nor", 4'b1100, 64'h0F0F_0000_0000_0000, 64'h0000_0000_0000_00FF, 64'hF0F0_FFFF_FFFF_FF00, 1'b0);
        single("passb", 4'b0111, 64'd9, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0);
        single("and", 4'b0000, 64'hF0, 64'h0F, 64'd0, 1'b1);
        single("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
        single("sub_wrap", 4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        single("bad_op", 4'b0011, 64'd5, 64'd7, 64'd0, 1'b1);

        // Backpressure: result held for 5 cycles, then one handshake
        out_ready = 1'b0;
        drive(4'b0001, 64'hF0, 64'h0F, 64'hFF, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
            check("bp_result", result, 64'hFF);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {63'd0, out_valid}, 64'd0);
        check("bp_release_ready", {63'd0, in_ready}, 64'd1);
        check("bp_result_kept", result, 64'hFF);

        // Reset in the middle of a MUL
        in_valid = 1'b1;
        alu_op   = 4'b1000;
        op_a     = 64'd3;
        op_b     = 64'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_result", result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mrst_in_ready", {63'd0, in_ready}, 64'd1);
        single("post_rst_add", 4'b0010, 64'd1, 64'd1, 64'd2, 1'b0);
        repeat (80) @(posedge clk);
        #1;
        check("no_stray_output", {63'd0, out_valid}, 64'd0);
        check("sb_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
